// File: rtl/r88_int_sequencer_if.sv
// Bundle between the interrupt sequencer and its neighbours (decoder, register file,
// memory bus interface).
//   master : the surrounding CPU side; drives requests, return state and memory responses.
//   slave  : the sequencer; drives the bus strobes, PC/SP load values and pulses.
interface r88_int_sequencer_if;
  // Requests and architectural state from the decoder / register file
  logic        instrBoundary;
  logic        nmiReq;
  logic        irq;
  logic        irqEn;
  logic        brkReq;
  logic [15:0] pcIn;
  logic [15:0] spIn;
  logic [7:0]  flagsIn;
  // Memory response
  logic        memAck;
  logic [7:0]  memDataIn;
  // Sequencer outputs
  logic        busy;
  logic        readMem;
  logic        writeMem;
  logic [15:0] memAddr;
  logic [7:0]  memDataOut;
  logic [15:0] pcOut;
  logic        pcLoad;
  logic [15:0] spOut;
  logic        spLoad;
  logic        irqDisable;
  logic        ackNmi;
  logic        ackIrq;

  modport master (
    output instrBoundary, nmiReq, irq, irqEn, brkReq, pcIn, spIn, flagsIn, memAck, memDataIn,
    input  busy, readMem, writeMem, memAddr, memDataOut, pcOut, pcLoad, spOut, spLoad,
           irqDisable, ackNmi, ackIrq
  );

  modport slave (
    input  instrBoundary, nmiReq, irq, irqEn, brkReq, pcIn, spIn, flagsIn, memAck, memDataIn,
    output busy, readMem, writeMem, memAddr, memDataOut, pcOut, pcLoad, spOut, spLoad,
           irqDisable, ackNmi, ackIrq
  );
endinterface

// File: rtl/r88_int_sequencer.sv
// Interrupt / reset sequencer. Arbitrates reset, NMI, BRK and IRQ at instruction
// boundaries. Interrupts push PCH, PCL and flags below the latched SP, fetch the
// 16-bit vector and load PC and SP. Reset fetches the reset vector only.
// Ports:
//   sysClock : clock, rising edge
//   resetReq : synchronous active-low reset
//   bus      : r88_int_sequencer_if.slave (requests, memory handshake, PC/SP outputs)
// All outputs are registered. The sequencer owns the memory bus while busy is high.
module r88_int_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'hFFFC,
  parameter logic [15:0] NMI_VEC   = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC   = 16'hFFFE,
  parameter int unsigned BRK_BIT   = 4
) (
  input logic                  sysClock,
  input logic                  resetReq,
  r88_int_sequencer_if.slave   bus
);

  localparam logic [7:0] BrkMask = 8'(1 << BRK_BIT);

  typedef enum logic [2:0] {
    StRstPend,
    StIdle,
    StPushPch,
    StPushPcl,
    StPushFlg,
    StVecLo,
    StVecHi,
    StLoad
  } state_e;

  state_e      stateQ;
  logic        nmiPrevQ;
  logic        nmiPendingQ;
  logic        isResetQ;
  logic [15:0] vecQ;
  logic [15:0] pcLatQ;
  logic [15:0] spLatQ;
  logic [7:0]  flagsLatQ;
  logic [7:0]  vecLoQ;

  logic        busyQ;
  logic        readMemQ;
  logic        writeMemQ;
  logic [15:0] memAddrQ;
  logic [7:0]  memDataOutQ;
  logic [15:0] pcOutQ;
  logic        pcLoadQ;
  logic [15:0] spOutQ;
  logic        spLoadQ;
  logic        irqDisableQ;
  logic        ackNmiQ;
  logic        ackIrqQ;

  logic        nmiEdge;
  logic        canAccept;
  logic        takeNmi;
  logic        takeBrk;
  logic        takeIrq;
  logic [7:0]  flagsSel;

  always_comb begin
    nmiEdge   = bus.nmiReq & ~nmiPrevQ;
    canAccept = (stateQ == StIdle) & bus.instrBoundary;
    takeNmi   = canAccept & nmiPendingQ;
    takeBrk   = canAccept & ~nmiPendingQ & bus.brkReq;
    takeIrq   = canAccept & ~nmiPendingQ & ~bus.brkReq & bus.irq & bus.irqEn;
    flagsSel  = takeBrk ? (bus.flagsIn | BrkMask) : (bus.flagsIn & ~BrkMask);
  end

  always_ff @(posedge sysClock) begin
    if (!resetReq) begin
      stateQ      <= StRstPend;
      nmiPrevQ    <= 1'b0;
      nmiPendingQ <= 1'b0;
      isResetQ    <= 1'b0;
      vecQ        <= 16'h0000;
      pcLatQ      <= 16'h0000;
      spLatQ      <= 16'h0000;
      flagsLatQ   <= 8'h00;
      vecLoQ      <= 8'h00;
      busyQ       <= 1'b0;
      readMemQ    <= 1'b0;
      writeMemQ   <= 1'b0;
      memAddrQ    <= 16'h0000;
      memDataOutQ <= 8'h00;
      pcOutQ      <= 16'h0000;
      pcLoadQ     <= 1'b0;
      spOutQ      <= 16'h0000;
      spLoadQ     <= 1'b0;
      irqDisableQ <= 1'b0;
      ackNmiQ     <= 1'b0;
      ackIrqQ     <= 1'b0;
    end else begin
      nmiPrevQ    <= bus.nmiReq;
      // A fresh edge in the accept cycle wins over the clear.
      nmiPendingQ <= nmiEdge | (nmiPendingQ & ~takeNmi);
      pcLoadQ     <= 1'b0;
      spLoadQ     <= 1'b0;
      irqDisableQ <= 1'b0;
      ackNmiQ     <= 1'b0;
      ackIrqQ     <= 1'b0;

      unique case (stateQ)
        StRstPend: begin
          stateQ   <= StVecLo;
          isResetQ <= 1'b1;
          vecQ     <= RESET_VEC;
          busyQ    <= 1'b1;
          readMemQ <= 1'b1;
          memAddrQ <= RESET_VEC;
        end
        StIdle: begin
          if (takeNmi || takeBrk || takeIrq) begin
            stateQ      <= StPushPch;
            isResetQ    <= 1'b0;
            vecQ        <= takeNmi ? NMI_VEC : IRQ_VEC;
            pcLatQ      <= bus.pcIn;
            spLatQ      <= bus.spIn;
            flagsLatQ   <= flagsSel;
            busyQ       <= 1'b1;
            writeMemQ   <= 1'b1;
            memAddrQ    <= bus.spIn;
            memDataOutQ <= bus.pcIn[15:8];
            ackNmiQ     <= takeNmi;
            ackIrqQ     <= takeIrq;
          end
        end
        StPushPch: begin
          if (bus.memAck) begin
            stateQ      <= StPushPcl;
            memAddrQ    <= spLatQ - 16'd1;
            memDataOutQ <= pcLatQ[7:0];
          end
        end
        StPushPcl: begin
          if (bus.memAck) begin
            stateQ      <= StPushFlg;
            memAddrQ    <= spLatQ - 16'd2;
            memDataOutQ <= flagsLatQ;
          end
        end
        StPushFlg: begin
          if (bus.memAck) begin
            stateQ    <= StVecLo;
            writeMemQ <= 1'b0;
            readMemQ  <= 1'b1;
            memAddrQ  <= vecQ;
          end
        end
        StVecLo: begin
          if (bus.memAck) begin
            stateQ   <= StVecHi;
            vecLoQ   <= bus.memDataIn;
            memAddrQ <= vecQ + 16'd1;
          end
        end
        StVecHi: begin
          if (bus.memAck) begin
            stateQ      <= StLoad;
            readMemQ    <= 1'b0;
            pcOutQ      <= {bus.memDataIn, vecLoQ};
            pcLoadQ     <= 1'b1;
            irqDisableQ <= 1'b1;
            // Reset path leaves SP to the register file's own reset value.
            if (!isResetQ) begin
              spOutQ  <= spLatQ - 16'd3;
              spLoadQ <= 1'b1;
            end
          end
        end
        StLoad: begin
          stateQ <= StIdle;
          busyQ  <= 1'b0;
        end
        default: begin
          stateQ    <= StRstPend;
          busyQ     <= 1'b0;
          readMemQ  <= 1'b0;
          writeMemQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busyQ;
  assign bus.readMem    = readMemQ;
  assign bus.writeMem   = writeMemQ;
  assign bus.memAddr    = memAddrQ;
  assign bus.memDataOut = memDataOutQ;
  assign bus.pcOut      = pcOutQ;
  assign bus.pcLoad     = pcLoadQ;
  assign bus.spOut      = spOutQ;
  assign bus.spLoad     = spLoadQ;
  assign bus.irqDisable = irqDisableQ;
  assign bus.ackNmi     = ackNmiQ;
  assign bus.ackIrq     = ackIrqQ;

endmodule

// File: tb/tb_r88_int_sequencer.sv
// Bench for r88_int_sequencer: a bus-operation-list model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_r88_int_sequencer;

  localparam logic [15:0] ResetVec = 16'hFFFC;
  localparam logic [15:0] NmiVec   = 16'hFFFA;
  localparam logic [15:0] IrqVec   = 16'hFFFE;

  logic sysClock = 1'b0;
  logic resetReq = 1'b0;
  always #5 sysClock = ~sysClock;

  r88_int_sequencer_if bus();

  r88_int_sequencer #(
    .RESET_VEC(ResetVec),
    .NMI_VEC  (NmiVec),
    .IRQ_VEC  (IrqVec),
    .BRK_BIT  (4)
  ) dut (
    .sysClock(sysClock),
    .resetReq(resetReq),
    .bus     (bus)
  );

  logic [7:0] mem [0:65535];
  assign bus.memDataIn = bus.readMem ? mem[bus.memAddr] : 8'h00;

  int tests = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Model: list of bus operations still to perform ----------------
  typedef struct {
    int          kind;   // 0 write, 1 read, 2 load PC/SP, 3 none
    logic [15:0] addr;
    logic [7:0]  data;
    logic        spLd;
    logic [15:0] sp;
  } op_t;

  op_t        ops[$];
  bit         rstPend = 1'b1;
  bit         nmiPend = 1'b0;
  bit         nmiPrev = 1'b0;
  bit         ackNE   = 1'b0;
  bit         ackIE   = 1'b0;
  logic [7:0] rdLo    = 8'h00;
  logic [7:0] rdHi    = 8'h00;

  function automatic op_t mkOp(int k, logic [15:0] a, logic [7:0] d, logic l, logic [15:0] s);
    op_t o;
    o.kind = k; o.addr = a; o.data = d; o.spLd = l; o.sp = s;
    return o;
  endfunction

  function automatic void startSeq(logic [15:0] vec, logic [15:0] pc, logic [15:0] sp,
                                   logic [7:0] flg);
    ops.push_back(mkOp(0, sp, pc[15:8], 1'b0, 16'h0));
    ops.push_back(mkOp(0, sp - 16'd1, pc[7:0], 1'b0, 16'h0));
    ops.push_back(mkOp(0, sp - 16'd2, flg, 1'b0, 16'h0));
    ops.push_back(mkOp(1, vec, 8'h00, 1'b0, 16'h0));
    ops.push_back(mkOp(1, vec + 16'd1, 8'h00, 1'b0, 16'h0));
    ops.push_back(mkOp(2, 16'h0, 8'h00, 1'b1, sp - 16'd3));
  endfunction

  initial begin : model
    bit nmiEdge;
    bit takeN;
    forever begin
      @(posedge sysClock);
      ackNE = 1'b0;
      ackIE = 1'b0;
      if (!resetReq) begin
        ops.delete();
        rstPend = 1'b1;
        nmiPend = 1'b0;
        nmiPrev = 1'b0;
      end else begin
        nmiEdge = bus.nmiReq && !nmiPrev;
        nmiPrev = bus.nmiReq;
        takeN   = 1'b0;
        if (rstPend) begin
          rstPend = 1'b0;
          ops.push_back(mkOp(1, ResetVec, 8'h00, 1'b0, 16'h0));
          ops.push_back(mkOp(1, ResetVec + 16'd1, 8'h00, 1'b0, 16'h0));
          ops.push_back(mkOp(2, 16'h0, 8'h00, 1'b0, 16'h0));
        end else if (ops.size() == 0) begin
          if (bus.instrBoundary) begin
            if (nmiPend) begin
              takeN = 1'b1;
              ackNE = 1'b1;
              startSeq(NmiVec, bus.pcIn, bus.spIn, bus.flagsIn & 8'hEF);
            end else if (bus.brkReq) begin
              startSeq(IrqVec, bus.pcIn, bus.spIn, bus.flagsIn | 8'h10);
            end else if (bus.irq && bus.irqEn) begin
              ackIE = 1'b1;
              startSeq(IrqVec, bus.pcIn, bus.spIn, bus.flagsIn & 8'hEF);
            end
          end
        end else if (ops[0].kind == 2) begin
          void'(ops.pop_front());
        end else if (bus.memAck) begin
          if (ops[0].kind == 1) begin
            rdLo = rdHi;
            rdHi = mem[ops[0].addr];
          end
          void'(ops.pop_front());
        end
        nmiPend = nmiEdge || (nmiPend && !takeN);
      end
    end
  end

  // ---------------- Per-cycle compare against the model ----------------
  initial begin : compare
    op_t h;
    bit  busyE;
    forever begin
      @(negedge sysClock);
      busyE = ops.size() != 0;
      if (busyE) h = ops[0];
      else h = mkOp(3, 16'h0, 8'h00, 1'b0, 16'h0);
      check("busy", 32'(bus.busy), 32'(busyE));
      check("strobes", 32'({bus.readMem, bus.writeMem}), 32'({h.kind == 1, h.kind == 0}));
      check("pulses", 32'({bus.pcLoad, bus.spLoad, bus.irqDisable, bus.ackNmi, bus.ackIrq}),
            32'({h.kind == 2, h.kind == 2 && h.spLd, h.kind == 2, ackNE, ackIE}));
      if (h.kind == 0 || h.kind == 1) check("memAddr", 32'(bus.memAddr), 32'(h.addr));
      if (h.kind == 0) check("memDataOut", 32'(bus.memDataOut), 32'(h.data));
      if (h.kind == 2) check("pcOut", 32'(bus.pcOut), 32'({rdHi, rdLo}));
      if (h.kind == 2 && h.spLd) check("spOut", 32'(bus.spOut), 32'(h.sp));
    end
  end

  // ---------------- Monitor for the directed literal checks ----------------
  int          cyc = 0;
  int          pcLoadCnt, nmiCnt, irqCnt, busyCyc, pcLoadCyc;
  logic [15:0] lastPc, lastSp;
  logic        lastSpLoad, lastIrqDis;
  logic [23:0] wrLog[$];
  logic [15:0] rdLog[$];

  always @(posedge sysClock) cyc <= cyc + 1;

  initial begin : monitor
    forever begin
      @(negedge sysClock);
      if (bus.pcLoad) begin
        pcLoadCnt++;
        pcLoadCyc  = cyc;
        lastPc     = bus.pcOut;
        lastSp     = bus.spOut;
        lastSpLoad = bus.spLoad;
        lastIrqDis = bus.irqDisable;
      end
      if (bus.ackNmi) nmiCnt++;
      if (bus.ackIrq) irqCnt++;
      if (bus.busy) busyCyc++;
      if (bus.writeMem && bus.memAck) wrLog.push_back({bus.memAddr, bus.memDataOut});
      if (bus.readMem && bus.memAck) rdLog.push_back(bus.memAddr);
    end
  end

  task automatic clearMon();
    pcLoadCnt = 0; nmiCnt = 0; irqCnt = 0; busyCyc = 0; pcLoadCyc = 0;
    lastPc = 16'h0; lastSp = 16'h0; lastSpLoad = 1'b0; lastIrqDis = 1'b0;
    wrLog.delete();
    rdLog.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sysClock);
    #2;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (bus.busy && n < 60) begin
      step(1);
      n++;
    end
    check("idle_timeout", 32'(n < 60), 32'd1);
  endtask

  // Present a request at one boundary, then drop the one-shot inputs.
  task automatic present(input logic [15:0] pc, input logic [15:0] sp, input logic [7:0] flg,
                         input logic brk, input logic irqV, input logic irqEnV);
    bus.pcIn = pc; bus.spIn = sp; bus.flagsIn = flg;
    bus.brkReq = brk; bus.irq = irqV; bus.irqEn = irqEnV;
    bus.instrBoundary = 1'b1;
    step(1);
    bus.instrBoundary = 1'b0; bus.brkReq = 1'b0; bus.irq = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int startCyc;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hA0;
    bus.instrBoundary = 1'b0; bus.nmiReq = 1'b0; bus.irq = 1'b0; bus.irqEn = 1'b0;
    bus.brkReq = 1'b0; bus.pcIn = 16'h0; bus.spIn = 16'h0; bus.flagsIn = 8'h00;
    bus.memAck = 1'b1;
    clearMon();
    step(3);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_addr", 32'(bus.memAddr), 32'd0);

    // Reset release: vector fetch only
    clearMon();
    startCyc = cyc;
    resetReq = 1'b1;
    step(1);
    waitIdle();
    check("rst_pc", 32'(lastPc), 32'h1234);
    check("rst_latency", 32'(pcLoadCyc - startCyc), 32'd3);
    check("rst_spLoad", 32'(lastSpLoad), 32'd0);
    check("rst_irqDis", 32'(lastIrqDis), 32'd1);
    check("rst_reads", 32'({rdLog[0], rdLog[1]}), 32'hFFFCFFFD);
    check("rst_nowrites", 32'(wrLog.size()), 32'd0);

    // Plain IRQ
    clearMon();
    startCyc = cyc;
    present(16'h8005, 16'h01FF, 8'h41, 1'b0, 1'b1, 1'b1);
    waitIdle();
    check("irq_ack", 32'(irqCnt), 32'd1);
    check("irq_wr0", 32'(wrLog[0]), 32'h01FF80);
    check("irq_wr1", 32'(wrLog[1]), 32'h01FE05);
    check("irq_wr2", 32'(wrLog[2]), 32'h01FD41);
    check("irq_reads", 32'({rdLog[0], rdLog[1]}), 32'hFFFEFFFF);
    check("irq_pc", 32'(lastPc), 32'hA000);
    check("irq_sp", 32'(lastSp), 32'h01FC);
    check("irq_together", 32'({lastSpLoad, lastIrqDis}), 32'h3);
    check("irq_latency", 32'(pcLoadCyc - startCyc), 32'd6);

    // Masked IRQ is ignored
    clearMon();
    bus.irq = 1'b1; bus.irqEn = 1'b0; bus.instrBoundary = 1'b1;
    step(3);
    bus.irq = 1'b0; bus.instrBoundary = 1'b0;
    step(1);
    check("masked_busy", 32'(busyCyc), 32'd0);
    check("masked_ack", 32'(irqCnt), 32'd0);

    // NMI pending beats BRK and IRQ; nmiReq stays high afterwards
    clearMon();
    bus.nmiReq = 1'b1;
    step(1);
    present(16'h4000, 16'h01F0, 8'hFF, 1'b1, 1'b1, 1'b1);
    waitIdle();
    check("prio_nmi", 32'(nmiCnt), 32'd1);
    check("prio_noirq", 32'(irqCnt), 32'd0);
    check("prio_pc", 32'(lastPc), 32'h9000);
    check("prio_flags", 32'(wrLog[2]), 32'h01EEEF);
    check("prio_reads", 32'(rdLog[0]), 32'hFFFA);

    // BRK alone, nmiReq still high: no further NMI, flags bit4 forced
    clearMon();
    present(16'h4100, 16'h01ED, 8'h00, 1'b1, 1'b0, 1'b0);
    waitIdle();
    check("brk_nonmi", 32'(nmiCnt), 32'd0);
    check("brk_flags", 32'(wrLog[2]), 32'h01EB10);
    check("brk_pc", 32'(lastPc), 32'hA000);

    // Second NMI edge during a sequence is taken at the next boundary
    clearMon();
    bus.nmiReq = 1'b0;
    step(1);
    bus.nmiReq = 1'b1;
    step(1);
    present(16'h5000, 16'h0180, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.nmiReq = 1'b0;
    step(1);
    bus.nmiReq = 1'b1;
    step(1);
    waitIdle();
    present(16'h5002, 16'h017D, 8'h00, 1'b0, 1'b0, 1'b0);
    waitIdle();
    check("nmi2_count", 32'(nmiCnt), 32'd2);

    // memAck low for 4 cycles in the PCL push
    clearMon();
    present(16'h1111, 16'h0300, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1);
    bus.memAck = 1'b0;
    step(4);
    bus.memAck = 1'b1;
    waitIdle();
    check("stall_busy", 32'(busyCyc), 32'd10);
    check("stall_wr1", 32'(wrLog[1]), 32'h02FF11);
    check("stall_writes", 32'(wrLog.size()), 32'd3);

    // SP wrap-around
    clearMon();
    present(16'hBEEF, 16'h0001, 8'h02, 1'b0, 1'b1, 1'b1);
    waitIdle();
    check("wrap_wr0", 32'(wrLog[0]), 32'h0001BE);
    check("wrap_wr1", 32'(wrLog[1]), 32'h0000EF);
    check("wrap_wr2", 32'(wrLog[2]), 32'hFFFF02);
    check("wrap_sp", 32'(lastSp), 32'hFFFE);

    // Reset during VEC_HI aborts with no load
    clearMon();
    present(16'h2222, 16'h0200, 8'h00, 1'b0, 1'b1, 1'b1);
    step(4);
    check("abort_at_vechi", 32'({bus.readMem, bus.memAddr}), 32'h1FFFF);
    resetReq = 1'b0;
    step(2);
    check("abort_noload", 32'(pcLoadCnt), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    clearMon();
    resetReq = 1'b1;
    step(1);
    waitIdle();
    check("abort_reload", 32'(pcLoadCnt), 32'd1);
    check("abort_pc", 32'(lastPc), 32'h1234);
    check("abort_vec", 32'(rdLog[0]), 32'hFFFC);

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/r88_int_sequencer.md
Name: r88_int_sequencer

Overview:
- Arbitrates reset, NMI, software break (BRK) and maskable IRQ requests at instruction boundaries.
- For NMI/BRK/IRQ it pushes PC high, PC low and the flags byte to the stack, fetches the 16-bit vector, then loads PC and SP.
- After reset it fetches the reset vector only; no stack pushes are made.
- It sits between the instruction decoder, the register file and the memory bus interface, and owns the bus while busy is high.

Parameters:
- RESET_VEC, 16'hFFFC, address of the reset vector low byte.
- NMI_VEC, 16'hFFFA, address of the NMI vector low byte.
- IRQ_VEC, 16'hFFFE, address of the IRQ/BRK vector low byte.
- BRK_BIT, 4, bit of the pushed flags byte that is forced to 1 for BRK and to 0 for NMI/IRQ.

Ports:
- sysClock  in  1  system clock; all logic is on its rising edge.
- resetReq  in  1  reset, synchronous, active-low.
- instrBoundary  in  1  decoder is at an instruction boundary; a request may be accepted.
- nmiReq  in  1  NMI request; rising-edge sensitive.
- irq  in  1  maskable interrupt request; level sensitive.
- irqEn  in  1  current interrupt-enable flag.
- brkReq  in  1  BRK opcode decoded; sampled only when instrBoundary=1.
- pcIn  in  16  return PC to push.
- spIn  in  16  current stack pointer.
- flagsIn  in  8  packed flags byte.
- memAck  in  1  memory access completes this cycle.
- memDataIn  in  8  read data; valid when memAck=1.
- busy  out  1  sequence in progress; the decoder stalls while high.
- readMem  out  1  memory read strobe.
- writeMem  out  1  memory write strobe.
- memAddr  out  16  bus address.
- memDataOut  out  8  write data.
- pcOut  out  16  new PC value.
- pcLoad  out  1  one-cycle pulse that loads PC from pcOut.
- spOut  out  16  new SP value.
- spLoad  out  1  one-cycle pulse that loads SP from spOut.
- irqDisable  out  1  one-cycle pulse that clears irqEn.
- ackNmi  out  1  one-cycle pulse when an NMI is accepted.
- ackIrq  out  1  one-cycle pulse when an IRQ is accepted.

Behaviour:
- Reset: while resetReq=0 at a clock edge:
  - state <= RST_PEND; nmiPending <= 0; NMI edge register <= 0.
  - All strobes, pulses, busy, memAddr, memDataOut, pcOut, spOut <= 0.
- States: RST_PEND, IDLE, PUSH_PCH, PUSH_PCL, PUSH_FLG, VEC_LO, VEC_HI, LOAD.
- RST_PEND: the first clock with resetReq=1 -> VEC_LO with vector=RESET_VEC and pushes skipped. busy=1 from that cycle.
- NMI edge detect: nmiPending is set on a 0->1 transition of nmiReq sampled in consecutive cycles. It is set in any state except under reset. It is cleared only when the NMI is accepted. A new edge in the accept cycle keeps nmiPending at 1.
- Accept from IDLE with instrBoundary=1, in priority order:
  1. nmiPending: vector NMI_VEC; ackNmi pulse.
  2. brkReq: vector IRQ_VEC; BRK_BIT forced to 1.
  3. irq & irqEn: vector IRQ_VEC; ackIrq pulse.
- Accept cycle actions:
  - Latch pcIn, spIn and flagsIn (with BRK_BIT forced to 1 for BRK, 0 otherwise).
  - Go to PUSH_PCH; busy=1 from the next cycle.
- Requests are ignored when instrBoundary=0. irq and irqEn are not sampled outside IDLE.
- Push states: writeMem=1, memAddr=SPlatched - k, with k=0 for PCH, 1 for PCL, 2 for FLG. Arithmetic is 16-bit modulo: SP=0x0001 gives addresses 0x0001, 0x0000, 0xFFFF.
- memDataOut = PC[15:8], then PC[7:0], then the flags byte.
- Vector states: readMem=1, memAddr = vector, then vector+1 (16-bit wrap). The low byte is captured in VEC_LO and the high byte in VEC_HI.
- Handshake: the strobe and address are held constant until a cycle with memAck=1, then the state advances on that edge. There is no timeout. memAck while idle is ignored.
- LOAD (one cycle), then IDLE with busy=0 in the following cycle:
  - pcOut = {hi, lo}; pcLoad=1.
  - Interrupt path: spOut = SPlatched - 3, spLoad=1, irqDisable=1.
  - Reset path: spLoad=0, irqDisable=1.
- Latency with memAck tied high: interrupt accept to pcLoad is 6 cycles; reset release to pcLoad is 3 cycles.
- Reset mid-sequence aborts immediately. No partial pcLoad or spLoad is issued, and the sequencer returns to RST_PEND.
- Exactly one of readMem or writeMem is high in a memory state. Both are 0 in IDLE, LOAD and RST_PEND.

Test Plan:
- Reset release, memAck=1, mem[FFFC]=0x34, mem[FFFD]=0x12 -> reads at FFFC then FFFD; pcOut=0x1234 with pcLoad 3 cycles after release; spLoad=0; irqDisable=1.
- IRQ: irq=1, irqEn=1, pcIn=0x8005, spIn=0x01FF, flagsIn=0x41, instrBoundary=1 -> ackIrq; writes 0x80@01FF, 0x05@01FE, 0x41@01FD; reads FFFE/FFFF; spOut=0x01FC; pcLoad, spLoad and irqDisable pulse together.
- Simultaneous NMI edge, brkReq and irq at the boundary -> NMI_VEC taken; nmiPending cleared; BRK and IRQ not taken. A BRK alone afterwards pushes flags with bit4=1.
- memAck held low 4 cycles during PUSH_PCL -> memAddr, writeMem and memDataOut stable throughout; advances only on the memAck cycle.
- irq=1, irqEn=0 -> no acceptance, busy stays 0. nmiReq held high -> only one NMI sequence; a second rising edge during that sequence -> a second NMI taken at the next boundary.
- spIn=0x0001 interrupt -> writes at 0001, 0000, FFFF; spOut=0xFFFE. resetReq=0 during VEC_HI -> no pcLoad; a fresh reset-vector fetch follows release.
